osecpu_sequencer: RTL

Multi-cycle control unit for the OSECPU core. It owns the PC, the fetch handshake to instruction memory, instruction latch/decode, and generation of integer-register-file and ALU control for LIMM16, CP, ADD, SUB, CPDR and END. It replaces the ad-hoc fetch/decode logic in the top level. It adds a memory wait handshake, a run/step gate, illegal-opcode trapping and a retired-instruction counter.

---
 rtl/osecpu_pkg.sv | 57 +++++
 rtl/osecpu_decode.sv | 68 ++++++
 rtl/osecpu_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/osecpu_pkg.sv
// Shared encodings for the OSECPU sequencer: FSM states, opcodes, ALU ops
// and instruction field positions.
package osecpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [7:0] OP_LIMM16 = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h14;
  localparam logic [7:0] OP_SUB    = 8'h15;
  localparam logic [7:0] OP_CP     = 8'hD2;
  localparam logic [7:0] OP_CPDR   = 8'hD3;
  localparam logic [7:0] OP_END    = 8'hF0;

  localparam logic [3:0] ALU_IDLE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd4;
  localparam logic [3:0] ALU_SUB  = 4'd5;

  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 24;
  localparam int unsigned O0_MSB  = 23;
  localparam int unsigned O0_LSB  = 18;
  localparam int unsigned O1_MSB  = 17;
  localparam int unsigned O1_LSB  = 12;
  localparam int unsigned O2_MSB  = 11;
  localparam int unsigned O2_LSB  = 6;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

  typedef struct packed {
    logic [7:0]  op;
    logic [5:0]  o0;
    logic [5:0]  o1;
    logic [5:0]  o2;
    logic [15:0] imm;
  } fields_t;

  // Fields overlap (imm16 shares bits with o1/o2); each opcode uses its own subset.
  function automatic fields_t split_instr(input logic [31:0] w);
    fields_t f;
    f.op  = w[OP_MSB:OP_LSB];
    f.o0  = w[O0_MSB:O0_LSB];
    f.o1  = w[O1_MSB:O1_LSB];
    f.o2  = w[O2_MSB:O2_LSB];
    f.imm = w[IMM_MSB:IMM_LSB];
    return f;
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/osecpu_decode.sv
// Combinational instruction decode: turns the latched instruction into
// register-file / ALU controls, active only during the EXEC state.
module osecpu_decode
  import osecpu_pkg::*;
#(
  parameter int unsigned REG_AW = 6
) (
  input  state_e              state_i,
  input  logic [31:0]         instr_i,
  input  logic [31:0]         ireg_d0_i,
  input  logic [31:0]         alu_dout_i,
  output logic [REG_AW-1:0]   ireg_r0_o,
  output logic [REG_AW-1:0]   ireg_r1_o,
  output logic [REG_AW-1:0]   ireg_rw_o,
  output logic [31:0]         ireg_dw_o,
  output logic                ireg_we_o,
  output logic [3:0]          alu_op_o,
  output logic                dr_we_o,
  output logic                is_end_o,
  output logic                is_illegal_o
);

  fields_t f;

  assign f = split_instr(instr_i);

  always_comb begin
    ireg_r0_o    = '0;
    ireg_r1_o    = '0;
    ireg_rw_o    = '0;
    ireg_dw_o    = '0;
    ireg_we_o    = 1'b0;
    alu_op_o     = ALU_IDLE;
    dr_we_o      = 1'b0;
    is_end_o     = 1'b0;
    is_illegal_o = 1'b0;
    if (state_i == ST_EXEC) begin
      case (f.op)
        OP_LIMM16: begin
          ireg_we_o = 1'b1;
          ireg_rw_o = REG_AW'(f.o0);
          ireg_dw_o = sext16(f.imm);
        end
        OP_CP: begin
          ireg_r0_o = REG_AW'(f.o1);
          ireg_we_o = 1'b1;
          ireg_rw_o = REG_AW'(f.o0);
          ireg_dw_o = ireg_d0_i;
        end
        OP_ADD, OP_SUB: begin
          ireg_r0_o = REG_AW'(f.o1);
          ireg_r1_o = REG_AW'(f.o2);
          alu_op_o  = (f.op == OP_ADD) ? ALU_ADD : ALU_SUB;
          ireg_we_o = 1'b1;
          ireg_rw_o = REG_AW'(f.o0);
          ireg_dw_o = alu_dout_i;
        end
        OP_CPDR: begin
          ireg_r0_o = REG_AW'(f.o1);
          dr_we_o   = 1'b1;
        end
        OP_END:  is_end_o     = 1'b1;
        default: is_illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/osecpu_sequencer.sv
// OSECPU multi-cycle control unit: PC, fetch handshake, instruction latch,
// run/step gating, END/illegal trapping and retired-instruction counting.
module osecpu_sequencer
  import osecpu_pkg::*;
#(
  parameter int unsigned          PC_W     = 16,
  parameter logic [PC_W-1:0]      RESET_PC = '0,
  parameter int unsigned          REG_AW   = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  output logic                mem_req,
  output logic [PC_W-1:0]     mem_addr,
  input  logic                mem_ack,
  input  logic [31:0]         mem_rdata,
  output logic [REG_AW-1:0]   ireg_r0,
  output logic [REG_AW-1:0]   ireg_r1,
  input  logic [31:0]         ireg_d0,
  output logic [REG_AW-1:0]   ireg_rw,
  output logic [31:0]         ireg_dw,
  output logic                ireg_we,
  output logic [3:0]          alu_op,
  input  logic [31:0]         alu_dout,
  output logic [31:0]         dr,
  output logic [PC_W-1:0]     pc,
  output logic                halted,
  output logic                illegal,
  output logic [31:0]         retired
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       dr_q, dr_d;
  logic [31:0]       retired_q, retired_d;
  logic              halted_q, halted_d;
  logic              illegal_q, illegal_d;

  logic              dr_we;
  logic              is_end;
  logic              is_illegal;

  osecpu_decode #(
    .REG_AW (REG_AW)
  ) u_decode (
    .state_i      (state_q),
    .instr_i      (instr_q),
    .ireg_d0_i    (ireg_d0),
    .alu_dout_i   (alu_dout),
    .ireg_r0_o    (ireg_r0),
    .ireg_r1_o    (ireg_r1),
    .ireg_rw_o    (ireg_rw),
    .ireg_dw_o    (ireg_dw),
    .ireg_we_o    (ireg_we),
    .alu_op_o     (alu_op),
    .dr_we_o      (dr_we),
    .is_end_o     (is_end),
    .is_illegal_o (is_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      dr_q      <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      dr_q      <= dr_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    dr_d      = dr_q;
    retired_d = retired_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      // run is not consulted here: a started fetch always completes and executes.
      ST_FETCH: begin
        if (mem_ack) begin
          instr_d = mem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        retired_d = retired_q + 32'd1;
        if (dr_we) dr_d = ireg_d0;
        if (is_end || is_illegal) begin
          halted_d  = 1'b1;
          illegal_d = is_illegal;
          state_d   = ST_HALT;
        end else begin
          state_d = run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_req  = (state_q == ST_FETCH);
  assign mem_addr = pc_q;
  assign dr       = dr_q;
  assign pc       = pc_q;
  assign halted   = halted_q;
  assign illegal  = illegal_q;
  assign retired  = retired_q;

endmodule
